// File: rtl/pipe_latch.sv
// Two-entry skid-buffered pipeline register with flush and a saturating stall counter.
// ready_o is registered, so there is no combinational path from ready_i back upstream.
module pipe_latch #(
  parameter int DATA_W   = 64,
  parameter int CTRL_W   = 8,
  parameter int CNT_W    = 16,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                accept, drain;

  assign valid_o     = (state_q != EMPTY);
  assign ready_o     = ready_q;
  assign ctrl_o      = m_ctrl_q;
  assign data_o      = m_data_q;
  assign stall_cnt_o = stall_cnt_q;

  assign accept = valid_i && ready_q;
  assign drain  = valid_o && ready_i;

  // NOTE: every signal gets a default at the top of the block so no path
  // through the case/if tree leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    m_ctrl_d    = m_ctrl_q;
    m_data_d    = m_data_q;
    s_ctrl_d    = s_ctrl_q;
    s_data_d    = s_data_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          m_ctrl_d = ctrl_i;
          m_data_d = data_i;
        end
      end
      ONE: begin
        if (accept && drain) begin
          m_ctrl_d = ctrl_i;
          m_data_d = data_i;
        end else if (drain) begin
          state_d  = EMPTY;
          m_ctrl_d = '0;
        end else if (accept) begin
          state_d  = FULL;
          s_ctrl_d = ctrl_i;
          s_data_d = data_i;
        end
      end
      FULL: begin
        // ready_o is low here, so the only possible event is a drain
        if (drain) begin
          state_d  = ONE;
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
          s_ctrl_d = '0;
        end
      end
      default: begin
        state_d  = EMPTY;
        m_ctrl_d = '0;
        s_ctrl_d = '0;
      end
    endcase

    if (flush_i) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      if (CLR_DATA) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end

    if (valid_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    ready_d = (state_d != FULL);
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      m_ctrl_q    <= '0;
      s_ctrl_q    <= '0;
      ready_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_ctrl_q    <= m_ctrl_d;
      s_ctrl_q    <= s_ctrl_d;
      ready_q     <= ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: the wide payload is only reset when CLR_DATA is set; otherwise it
  // is qualified by valid_o and left without a reset to keep the datapath lean.
  always_ff @(posedge clk_i) begin
    if (rst_i && CLR_DATA) begin
      m_data_q <= '0;
      s_data_q <= '0;
    end else begin
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_latch.sv
// Directed and randomized checks of pipe_latch: one instance clears data and
// has a 3-bit counter, a second keeps data and a 16-bit counter.
module tb_pipe_latch;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, flush_i, ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          a_ready_o, a_valid_o, b_ready_o, b_valid_o;
  logic [CW-1:0] a_ctrl_o, b_ctrl_o;
  logic [DW-1:0] a_data_o, b_data_o;
  logic [2:0]    a_stall_o;
  logic [15:0]   b_stall_o;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        sb[$];
  logic [DW-1:0] seq;
  logic          acc;

  always #5 clk = ~clk;

  pipe_latch #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3), .CLR_DATA(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(a_ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(a_valid_o),
    .ready_i(ready_i), .ctrl_o(a_ctrl_o), .data_o(a_data_o), .stall_cnt_o(a_stall_o)
  );

  pipe_latch #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .CLR_DATA(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(b_ready_o),
    .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(b_valid_o),
    .ready_i(ready_i), .ctrl_o(b_ctrl_o), .data_o(b_data_o), .stall_cnt_o(b_stall_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
    valid_i = v; ctrl_i = c; data_i = d; ready_i = r; flush_i = f;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    check("rst_valid", a_valid_o, 0);
    check("rst_ready", a_ready_o, 1);
    check("rst_ctrl", a_ctrl_o, 0);
    check("rst_stall", a_stall_o, 0);
    check("rst_data_clr", a_data_o, 0);
    check("rst_stall_b", b_stall_o, 0);
    rst_i = 1'b0;

    // Streaming: 1..10 back to back, each visible one cycle after its accept
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
      check("stream_ready", a_ready_o, 1);
      tick();
      check("stream_valid", a_valid_o, 1);
      check("stream_data", a_data_o, i);
      check("stream_ctrl", a_ctrl_o, i);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("stream_end_valid", a_valid_o, 0);
    check("stream_end_ctrl", a_ctrl_o, 0);
    check("stream_stall", a_stall_o, 0);

    // Backpressure: A then B accepted with ready_i low, four stalled cycles
    drive(1'b1, 8'h0A, 16'h000A, 1'b0, 1'b0);
    tick();
    check("bp_a_valid", a_valid_o, 1);
    check("bp_a_ready", a_ready_o, 1);
    drive(1'b1, 8'h0B, 16'h000B, 1'b0, 1'b0);
    tick();
    check("bp_full_ready", a_ready_o, 0);
    check("bp_hold_a", a_data_o, 16'h000A);
    check("bp_stall1", a_stall_o, 1);
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 8'hEE, 16'h00EE, 1'b0, 1'b0);
      tick();
      check("bp_hold", a_data_o, 16'h000A);
      check("bp_ready_lo", a_ready_o, 0);
      check("bp_stall", a_stall_o, i);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("bp_b_data", a_data_o, 16'h000B);
    check("bp_b_ctrl", a_ctrl_o, 8'h0B);
    check("bp_ready_back", a_ready_o, 1);
    tick();
    check("bp_empty", a_valid_o, 0);
    check("bp_stall_hold", a_stall_o, 4);

    // Flush in FULL with an incoming entry that must be discarded
    drive(1'b1, 8'h11, 16'h0011, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h22, 16'h0022, 1'b0, 1'b0);
    tick();
    check("fl_full", a_ready_o, 0);
    drive(1'b1, 8'hFF, 16'h0033, 1'b0, 1'b1);
    tick();
    check("fl_valid", a_valid_o, 0);
    check("fl_ctrl", a_ctrl_o, 0);
    check("fl_ready", a_ready_o, 1);
    check("fl_data_clr", a_data_o, 0);
    check("fl_data_kept_b", b_data_o, 16'h0011);
    check("fl_ctrl_b", b_ctrl_o, 0);
    check("fl_stall_kept", a_stall_o, 6);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("fl_not_seen", a_valid_o, 0);

    // Saturation of the 3-bit counter; 16-bit counter keeps counting
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(1'b1, 8'h44, 16'h0044, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("sat_a", a_stall_o, (i > 7) ? 7 : i);
    end
    check("sat_b", b_stall_o, 12);
    check("sat_hold_data", a_data_o, 16'h0044);

    // Reset with flush and valid in FULL
    drive(1'b1, 8'h55, 16'h0055, 1'b0, 1'b0);
    tick();
    check("rm_full", a_ready_o, 0);
    rst_i = 1'b1;
    drive(1'b1, 8'hFF, 16'h0077, 1'b0, 1'b1);
    tick();
    rst_i = 1'b0;
    check("rm_valid", a_valid_o, 0);
    check("rm_ready", a_ready_o, 1);
    check("rm_stall", a_stall_o, 0);
    check("rm_ctrl", a_ctrl_o, 0);
    check("rm_data", a_data_o, 0);
    drive(1'b1, 8'h66, 16'h0066, 1'b1, 1'b0);
    tick();
    check("rm_first_acc", a_data_o, 16'h0066);
    check("rm_first_valid", a_valid_o, 1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("rm_drained", a_valid_o, 0);

    // Random ordering run against a queue scoreboard
    seq = 16'h1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive($urandom_range(3) != 0, CW'($urandom), seq, 1'($urandom_range(1)),
            $urandom_range(31) == 0);
      seq = seq + 16'd1;
      check("rnd_valid", a_valid_o, sb.size() != 0);
      check("rnd_ready", a_ready_o, sb.size() < 2);
      check("rnd_valid_b", b_valid_o, sb.size() != 0);
      if (a_valid_o && ready_i && sb.size() != 0) begin
        check("rnd_data", a_data_o, sb[0].data);
        check("rnd_ctrl", a_ctrl_o, sb[0].ctrl);
        void'(sb.pop_front());
      end else if (!a_valid_o) begin
        check("rnd_idle_ctrl", a_ctrl_o, 0);
      end
      acc = valid_i && a_ready_o;
      if (flush_i) sb.delete();
      else if (acc) sb.push_back('{ctrl: ctrl_i, data: data_i});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
